register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised multi-port successor of the core register file: N combinational read ports, M write ports, optional write-to-read bypass, plus a per-register pending-write scoreboard.
- The scoreboard is a saturating counter per register, so the core can issue several in-flight producers to one register (WAW) and stall consumers correctly.
- Sits between decode (reads, issue) and writeback (writes) in the core pipeline.
- Keeps the R0 initialisation path used by the dispatcher.

Parameters:
- REG_COUNT, 16, number of registers.
- REG_SIZE, 8, register width in bits.
- REG_PTR_SIZE, 4, register index width; must satisfy 2^REG_PTR_SIZE >= REG_COUNT.
- READ_PORTS, 3, number of read ports.
- WRITE_PORTS, 2, number of write ports.
- PEND_W, 2, pending-counter width; maximum count is 2^PEND_W-1.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_RF  in  1  synchronous, active-high reset.
- init_R0  in  1  load R0 from init_R0_data this cycle.
- init_R0_data  in  REG_SIZE  R0 load value.
- rd_addr  in  READ_PORTS*REG_PTR_SIZE  read indices; port k occupies bits [k*REG_PTR_SIZE +: REG_PTR_SIZE].
- rd_data  out  READ_PORTS*REG_SIZE  read data, packed the same way.
- rd_busy  out  READ_PORTS  addressed register has a pending write that is not satisfied this cycle.
- wr_en  in  WRITE_PORTS  per-port write strobe.
- wr_addr  in  WRITE_PORTS*REG_PTR_SIZE  write indices.
- wr_data  in  WRITE_PORTS*REG_SIZE  write data.
- iss_en  in  1  issue: an instruction that will write iss_dst has been issued.
- iss_dst  in  REG_PTR_SIZE  destination of the issued instruction.
- iss_ready  out  1  pend[iss_dst] is below maximum, so an issue can be accepted.
- busy_vec  out  REG_COUNT  bit i = (pend[i] != 0).

Behaviour:
State
- r[REG_COUNT] (REG_SIZE bits) and pend[REG_COUNT] (PEND_W bits).

Reset
- reset_RF=1 at a clock edge: all r=0, all pend=0. Reset overrides init_R0, wr_en and iss_en in the same cycle.
- Outputs after reset: rd_data=0 for every in-range index, rd_busy=0, busy_vec=0, iss_ready=1.

Reads (combinational, zero latency)
- rd_data[k] = r[rd_addr[k]].
- If BYPASS=1 and any wr_en[j] has wr_addr[j]==rd_addr[k], rd_data[k] = wr_data of the highest such j.
- If init_R0=1 and rd_addr[k]==0, the R0 bypass returns init_R0_data. This forwarding applies only when BYPASS=1.
- Out-of-range indices (>= REG_COUNT) read 0 with rd_busy=0.

rd_busy
- rd_busy[k] = (pend[rd_addr[k]] != 0) & ~(BYPASS & write hit on rd_addr[k] & pend[rd_addr[k]] == 1).
- When more than one write is pending, forwarding one write does not clear busy.

Writes (registered, one-cycle latency)
- Several ports writing the same register in one cycle: the highest port index wins the data.
- init_R0=1 overrides every write port for R0's data.
- Writes to out-of-range indices are ignored.

Scoreboard, per register i, each cycle
- inc = iss_en & iss_ready & (iss_dst==i).
- dec = number of wr_en[j] with wr_addr[j]==i.
- pend_next = pend + inc - dec, clamped to 0 from below.
- Writes to an untracked register (pend=0) are legal; pend stays 0.
- Issue and write to the same register in one cycle: net change is inc-dec (issue 1 + write 1 → unchanged).
- iss_en with iss_ready=0 is ignored: no counter change. Issuing is the caller's responsibility to stall.
- iss_ready is combinational on iss_dst. It does not account for same-cycle decrements (conservative).
- init_R0 does not touch pend[0].

Reset mid-operation
- All in-flight pending counts are discarded. Later writebacks to those registers see pend=0 and leave it at 0.

Decomposition:
- Shared constants header gains RF_READ_PORTS, RF_WRITE_PORTS, RF_PEND_W and RF_BYPASS defaults next to the existing REG_COUNT, REG_SIZE and REG_PTR_SIZE.
- One natural sub-module: rf_scoreboard. It holds the pend array, inc/dec/clamp logic, busy_vec and iss_ready.
- Data array, write-priority mux and bypass muxes stay in the top module, built with generate loops over ports and registers.

Test Plan:
- Reset, then read all registers on 3 ports → rd_data=0, rd_busy=0, busy_vec=0, iss_ready=1.
- wr_en[0], wr_addr=5, wr_data=8'hA5 with rd_addr[1]=5 in the same cycle → BYPASS=1: rd_data[1]=A5 that cycle. BYPASS=0: old value that cycle, A5 next cycle.
- Ports 0 and 1 both write R3 (0x11, 0x22) → R3=0x22. An earlier pend[3]=2 drops to 0.
- Issue R7 three times (PEND_W=2) → busy_vec[7]=1 and iss_ready=1 throughout; pend=3 afterwards.
  - A 4th issue sees iss_ready=0 and is ignored.
  - Three writebacks return pend to 0.
  - rd_busy on R7 drops only in the cycle of the last forwarded write.
- Same cycle: iss_en for R2, write R2, init_R0=1 with 0x5A, write port 1 to R0 with 0x33 → pend[2] unchanged, R0=0x5A, R2 updated.
- Reset asserted while pend[4]=2, then two writebacks to R4 → pend[4] stays 0, R4 holds the last written data.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared register-file constants: default geometry and port counts for the
// multi-port register file and its pending-write scoreboard.
package register_file_mp_pkg;

  localparam int RF_REG_COUNT    = 16;
  localparam int RF_REG_SIZE     = 8;
  localparam int RF_REG_PTR_SIZE = 4;
  localparam int RF_READ_PORTS   = 3;
  localparam int RF_WRITE_PORTS  = 2;
  localparam int RF_PEND_W       = 2;
  localparam int RF_BYPASS       = 1;

  // Number of indices addressable by a pointer of the given width.
  function automatic int ptr_span(input int ptr_size);
    return 1 << ptr_size;
  endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// rf_scoreboard: per-register saturating pending-write counters.
// Issues increment, writebacks decrement (clamped at zero).
module rf_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int REG_COUNT    = RF_REG_COUNT,
  parameter int REG_PTR_SIZE = RF_REG_PTR_SIZE,
  parameter int WRITE_PORTS  = RF_WRITE_PORTS,
  parameter int PEND_W       = RF_PEND_W
) (
  input  logic                                clk,
  input  logic                                srst,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  input  logic [WRITE_PORTS*REG_PTR_SIZE-1:0] wr_addr,
  input  logic                                iss_en,
  input  logic [REG_PTR_SIZE-1:0]             iss_dst,
  output logic                                iss_ready,
  output logic [REG_COUNT-1:0]                busy_vec,
  output logic [REG_COUNT-1:0]                pend_one
);

  localparam int PTR_SPAN = ptr_span(REG_PTR_SIZE);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Padded to the full pointer range; nonexistent registers never accept issues.
  logic [PTR_SPAN-1:0] full_pad;

  assign iss_ready = ~full_pad[iss_dst];

  genvar gi;
  for (gi = 0; gi < PTR_SPAN; gi++) begin : g_pend
    if (gi < REG_COUNT) begin : g_live
      logic [PEND_W-1:0] pend_reg;
      logic [PEND_W-1:0] pend_next;
      int                cnt;

      // inc is gated by iss_ready, so pend+inc never exceeds PEND_MAX.
      always_comb begin
        cnt = int'(pend_reg);
        if (iss_en && iss_ready && (iss_dst == REG_PTR_SIZE'(gi))) begin
          cnt = cnt + 1;
        end
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (wr_en[j] && (wr_addr[j*REG_PTR_SIZE +: REG_PTR_SIZE] == REG_PTR_SIZE'(gi))) begin
            cnt = cnt - 1;
          end
        end
        if (cnt < 0) begin
          cnt = 0;
        end
        pend_next = cnt[PEND_W-1:0];
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          pend_reg <= '0;
        end else begin
          pend_reg <= pend_next;
        end
      end

      assign full_pad[gi] = (pend_reg == PEND_MAX);
      assign busy_vec[gi] = (pend_reg != '0);
      assign pend_one[gi] = (pend_reg == PEND_W'(1));
    end else begin : g_pad
      assign full_pad[gi] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: combinational reads with optional same-cycle
// write forwarding, prioritised registered writes, R0 init path, scoreboard.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int REG_COUNT    = RF_REG_COUNT,
  parameter int REG_SIZE     = RF_REG_SIZE,
  parameter int REG_PTR_SIZE = RF_REG_PTR_SIZE,
  parameter int READ_PORTS   = RF_READ_PORTS,
  parameter int WRITE_PORTS  = RF_WRITE_PORTS,
  parameter int PEND_W       = RF_PEND_W,
  parameter int BYPASS       = RF_BYPASS
) (
  input  logic                                clk,
  input  logic                                reset_RF,
  input  logic                                init_R0,
  input  logic [REG_SIZE-1:0]                 init_R0_data,
  input  logic [READ_PORTS*REG_PTR_SIZE-1:0]  rd_addr,
  output logic [READ_PORTS*REG_SIZE-1:0]      rd_data,
  output logic [READ_PORTS-1:0]               rd_busy,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  input  logic [WRITE_PORTS*REG_PTR_SIZE-1:0] wr_addr,
  input  logic [WRITE_PORTS*REG_SIZE-1:0]     wr_data,
  input  logic                                iss_en,
  input  logic [REG_PTR_SIZE-1:0]             iss_dst,
  output logic                                iss_ready,
  output logic [REG_COUNT-1:0]                busy_vec
);

  localparam int PTR_SPAN = ptr_span(REG_PTR_SIZE);

  // Everything indexed by a read pointer is padded to the full pointer range
  // so out-of-range indices read as zero / not busy.
  logic [PTR_SPAN-1:0][REG_SIZE-1:0] r_flat;
  logic [PTR_SPAN-1:0]               in_range;
  logic [PTR_SPAN-1:0]               busy_pad;
  logic [PTR_SPAN-1:0]               one_pad;
  logic [REG_COUNT-1:0]              pend_one;

  rf_scoreboard #(
    .REG_COUNT    (REG_COUNT),
    .REG_PTR_SIZE (REG_PTR_SIZE),
    .WRITE_PORTS  (WRITE_PORTS),
    .PEND_W       (PEND_W)
  ) u_scoreboard (
    .clk       (clk),
    .srst      (reset_RF),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec),
    .pend_one  (pend_one)
  );

  genvar gi;
  for (gi = 0; gi < PTR_SPAN; gi++) begin : g_reg
    if (gi < REG_COUNT) begin : g_live
      logic [REG_SIZE-1:0] r_reg;
      logic [REG_SIZE-1:0] r_next;

      // Ascending scan: the highest matching port wins; init_R0 beats all ports.
      always_comb begin
        r_next = r_reg;
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (wr_en[j] && (wr_addr[j*REG_PTR_SIZE +: REG_PTR_SIZE] == REG_PTR_SIZE'(gi))) begin
            r_next = wr_data[j*REG_SIZE +: REG_SIZE];
          end
        end
        if ((gi == 0) && init_R0) begin
          r_next = init_R0_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset_RF) begin
          r_reg <= '0;
        end else begin
          r_reg <= r_next;
        end
      end

      assign r_flat[gi]   = r_reg;
      assign in_range[gi] = 1'b1;
      assign busy_pad[gi] = busy_vec[gi];
      assign one_pad[gi]  = pend_one[gi];
    end else begin : g_pad
      assign r_flat[gi]   = '0;
      assign in_range[gi] = 1'b0;
      assign busy_pad[gi] = 1'b0;
      assign one_pad[gi]  = 1'b0;
    end
  end

  genvar gk;
  for (gk = 0; gk < READ_PORTS; gk++) begin : g_rd
    logic [REG_PTR_SIZE-1:0] addr;
    logic [REG_SIZE-1:0]     data;
    logic                    hit;

    assign addr = rd_addr[gk*REG_PTR_SIZE +: REG_PTR_SIZE];

    always_comb begin
      data = r_flat[addr];
      hit  = 1'b0;
      if ((BYPASS != 0) && in_range[addr]) begin
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (wr_en[j] && (wr_addr[j*REG_PTR_SIZE +: REG_PTR_SIZE] == addr)) begin
            data = wr_data[j*REG_SIZE +: REG_SIZE];
            hit  = 1'b1;
          end
        end
        if (init_R0 && (addr == '0)) begin
          data = init_R0_data;
        end
      end
    end

    // A forwarded write only satisfies the consumer if it is the last one pending.
    assign rd_data[gk*REG_SIZE +: REG_SIZE] = data;
    assign rd_busy[gk] = busy_pad[addr] & ~(hit & one_pad[addr]);
  end

endmodule
